// File: rtl/altera_ldpc_wimedia_enc_parity_seq.sv
// WiMedia LDPC encoder parity sequencer: accumulates info beats against ROM rows, then streams 8 parity words.
// Optional in_last consistency check enabled by defining ALTERA_LDPC_ENC_SEQ_LAST_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for first info beat of a frame
// ACCUM | accepting info beats, bcnt addresses the ROM
// DRAIN | last beat accepted, waiting for its ROM word to be folded in
// OUT   | presenting acc[par_idx] until all 8 words are transferred
module altera_ldpc_wimedia_enc_parity_seq #(
    parameter int NB_ADDR   = 3,
    parameter int NUM_BEATS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [29:0]              in_data,
    input  logic                     in_last,
    output logic [NB_ADDR-1:0][4:0]  in_addr,
    input  logic [7:0][29:0]         out_data_ROM,
    output logic                     par_valid,
    input  logic                     par_ready,
    output logic [29:0]              par_data,
    output logic [2:0]               par_idx,
    output logic                     par_last,
    output logic                     frame_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;
    localparam logic [4:0] LAST_BEAT = 5'(NUM_BEATS - 1);

    logic [1:0]       state;
    logic [4:0]       bcnt;
    logic             accept;
    logic             last_beat;
    logic             v_d1, v_d2;
    logic             first_d1, first_d2;
    logic             last_d1, last_d2;
    logic [29:0]      data_d1, data_d2;
    logic [7:0][29:0] acc;

    assign in_ready  = !rst && (state == S_IDLE || state == S_ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_beat = (bcnt == LAST_BEAT);

    always_comb begin
        for (int i = 0; i < NB_ADDR; i++) begin
            in_addr[i] = bcnt;
        end
    end

    assign par_valid = (state == S_OUT);
    assign par_data  = par_valid ? acc[par_idx] : '0;
    assign par_last  = par_valid && (par_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bcnt     <= '0;
            par_idx  <= '0;
            v_d1     <= 1'b0;
            v_d2     <= 1'b0;
            first_d1 <= 1'b0;
            first_d2 <= 1'b0;
            last_d1  <= 1'b0;
            last_d2  <= 1'b0;
            data_d1  <= '0;
            data_d2  <= '0;
            acc      <= '0;
        end else begin
            // Two stages so each beat meets its ROM row two cycles after addressing.
            v_d1     <= accept;
            first_d1 <= (bcnt == 5'd0);
            last_d1  <= last_beat;
            data_d1  <= in_data;
            v_d2     <= v_d1;
            first_d2 <= first_d1;
            last_d2  <= last_d1;
            data_d2  <= data_d1;

            if (v_d2) begin
                for (int j = 0; j < 8; j++) begin
                    acc[j] <= first_d2 ? (data_d2 & out_data_ROM[j])
                                       : (acc[j] ^ (data_d2 & out_data_ROM[j]));
                end
            end

            if (accept) begin
                bcnt <= last_beat ? 5'd0 : bcnt + 5'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) state <= last_beat ? S_DRAIN : S_ACCUM;
                end
                S_ACCUM: begin
                    if (accept && last_beat) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (v_d2 && last_d2) state <= S_OUT;
                end
                S_OUT: begin
                    if (par_ready) begin
                        if (par_idx == 3'd7) begin
                            state   <= S_IDLE;
                            par_idx <= 3'd0;
                        end else begin
                            par_idx <= par_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALTERA_LDPC_ENC_SEQ_LAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && (in_last != last_beat);
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_err      = 1'b0;
`endif

endmodule

// File: tb/tb_altera_ldpc_wimedia_enc_parity_seq.sv
// Scoreboard bench for the LDPC parity sequencer: driver pushes expected parity words, monitor pops on transfer.
module tb_altera_ldpc_wimedia_enc_parity_seq;

    localparam int NB     = 3;
    localparam int NBEATS = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready, in_last;
    logic [29:0]         in_data;
    logic [NB-1:0][4:0]  in_addr;
    logic [7:0][29:0]    out_data_ROM;
    logic                par_valid, par_ready, par_last, frame_err;
    logic [29:0]         par_data;
    logic [2:0]          par_idx;

    int errors = 0;
    int checks = 0;
    bit rom_ones;
    logic [4:0]  a1, a2;
    logic [29:0] exp_acc [8];

    typedef struct {
        logic [29:0] d;
        logic [2:0]  idx;
        logic        last;
    } exp_t;
    exp_t sb [$];

    altera_ldpc_wimedia_enc_parity_seq #(.NB_ADDR(NB), .NUM_BEATS(NBEATS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .in_addr(in_addr), .out_data_ROM(out_data_ROM),
        .par_valid(par_valid), .par_ready(par_ready), .par_data(par_data),
        .par_idx(par_idx), .par_last(par_last), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] rom_word(input logic [4:0] a, input int j, input bit ones);
        if (ones) return 30'h3FFF_FFFF;
        return 30'((32'(a) + 1) * 32'h0009_E377 * (j + 1)) ^ 30'h2A5A_5A5A;
    endfunction

    function automatic logic [29:0] data_word(input int f, input int i);
        return 30'(32'h1357_9BDF * (f * 32 + i + 1)) ^ 30'(i << 7);
    endfunction

    // ROM model with two-cycle read latency
    always @(posedge clk) begin
        a1 <= in_addr[0];
        a2 <= a1;
    end
    always_comb begin
        for (int j = 0; j < 8; j++) out_data_ROM[j] = rom_word(a2, j, rom_ones);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && par_valid && par_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_parity: got idx %0d data %h expected no word", par_idx, par_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("par_data", 32'(par_data), 32'(e.d));
                check("par_idx", 32'(par_idx), 32'(e.idx));
                check("par_last", 32'(par_last), 32'(e.last));
            end
        end
    end

    task automatic send_frame(input int f, input int gap_at, input int gap_len,
                              input int rst_at, input int err_at, input bit tcheck);
        int w;
        logic exp_err;
        for (int i = 0; i < NBEATS; i++) begin
            if (i == rst_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                check("rst_in_ready", 32'(in_ready), 32'd1);
                check("rst_par_valid", 32'(par_valid), 32'd0);
                check("rst_in_addr", 32'(in_addr[0]), 32'd0);
                check("rst_frame_err", 32'(frame_err), 32'd0);
                return;
            end
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                    check("gap_addr", 32'(in_addr[0]), 32'(i));
                end
            end
            in_valid = 1'b1;
            in_data  = data_word(f, i);
            in_last  = (i == NBEATS - 1) || (i == err_at);
            for (int j = 0; j < 8; j++)
                exp_acc[j] = ((i == 0) ? 30'h0 : exp_acc[j]) ^ (in_data & rom_word(5'(i), j, rom_ones));
            w = 0;
            while (!in_ready) begin
                @(posedge clk); #1;
                w++;
                if (w > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got in_ready 0 expected 1 beat %0d", i);
                    in_valid = 1'b0;
                    return;
                end
            end
            for (int k = 0; k < NB; k++) check("in_addr", 32'(in_addr[k]), 32'(i));
            @(posedge clk); #1;
            in_valid = 1'b0;
`ifdef ALTERA_LDPC_ENC_SEQ_LAST_CHECK_EN
            exp_err = (i == err_at);
`else
            exp_err = 1'b0;
`endif
            check("frame_err", 32'(frame_err), 32'(exp_err));
        end
        for (int k = 0; k < 8; k++) sb.push_back('{d: exp_acc[k], idx: 3'(k), last: (k == 7)});
        if (tcheck) begin
            check("par_valid_t1", 32'(par_valid), 32'd0);
            @(posedge clk); #1;
            check("par_valid_t2", 32'(par_valid), 32'd0);
            @(posedge clk); #1;
            check("par_valid_t3", 32'(par_valid), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(in_ready && !par_valid && sb.size() == 0)) begin
            @(posedge clk); #1;
            w++;
            if (w > 300) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: got %0d words pending expected 0", sb.size());
                return;
            end
        end
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        par_ready = 1'b1; rom_ones = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_par_valid", 32'(par_valid), 32'd0);
        check("reset_par_last", 32'(par_last), 32'd0);
        check("reset_par_data", 32'(par_data), 32'd0);
        check("reset_in_addr", 32'(in_addr[0]), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // all-ones ROM, back-to-back beats, latency check
        send_frame(0, -1, 0, -1, -1, 1'b1);
        wait_idle();

        // address-dependent ROM, then same frame with a 5-cycle gap at beat 10
        rom_ones = 1'b0;
        send_frame(1, -1, 0, -1, -1, 1'b0);
        wait_idle();
        send_frame(1, 10, 5, -1, -1, 1'b0);
        wait_idle();

        // downstream stall at par_idx 3
        send_frame(2, -1, 0, -1, -1, 1'b0);
        w = 0;
        while (!(par_valid && par_idx == 3'd3) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("stall_reached", 32'(par_valid && par_idx == 3'd3), 32'd1);
        par_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("stall_idx", 32'(par_idx), 32'd3);
            check("stall_data", 32'(par_data), 32'(exp_acc[3]));
            check("stall_valid", 32'(par_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        par_ready = 1'b1;
        wait_idle();

        // reset at beat 12 aborts frame, next frame from cleared state
        send_frame(3, -1, 0, 12, -1, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_par_valid", 32'(par_valid), 32'd0);
        end
        send_frame(4, -1, 0, -1, -1, 1'b0);
        wait_idle();

        // spurious in_last on beat 5
        send_frame(5, -1, 0, -1, 5, 1'b0);
        wait_idle();

        // two frames back to back
        send_frame(6, -1, 0, -1, -1, 1'b0);
        send_frame(7, -1, 0, -1, -1, 1'b0);
        wait_idle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
